// File: rtl/crop_frame_ctrl_if.sv
// Crop request handshake and upstream pixel handshake of crop_frame_ctrl.
// slave: the controller's view; master: the requester / pixel source view.
interface crop_frame_ctrl_if #(
  parameter int unsigned XW = 5,
  parameter int unsigned YW = 5
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [XW-1:0] cfg_x0;
  logic [YW-1:0] cfg_y0;
  logic          s_axis_tvalid;
  logic          s_axis_tready;

  modport slave (
    input  cfg_valid,
    input  cfg_x0,
    input  cfg_y0,
    input  s_axis_tvalid,
    output cfg_ready,
    output s_axis_tready
  );

  modport master (
    output cfg_valid,
    output cfg_x0,
    output cfg_y0,
    output s_axis_tvalid,
    input  cfg_ready,
    input  s_axis_tready
  );
endinterface

// File: rtl/crop_frame_ctrl.sv
// Per-frame sequencer for the crop filter: accepts and clamps a crop request, pulses ap_start,
// gates the input stream during RUN, tracks the raster position and closes the frame once all
// input beats are consumed and the filter has reported done.
// Optional DRAIN watchdog: define CROP_CTRL_TIMEOUT_EN.
module crop_frame_ctrl #(
  parameter int unsigned IN_ROWS        = 20,
  parameter int unsigned IN_COLS        = 20,
  parameter int unsigned OUT_ROWS       = 10,
  parameter int unsigned OUT_COLS       = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned XW = (IN_COLS > 1) ? $clog2(IN_COLS) : 1,
  localparam int unsigned YW = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    srst,
  crop_frame_ctrl_if.slave        cfg_axis,
  input  logic                    cf_s_axis_tready,
  input  logic                    cf_ap_ready,
  input  logic                    cf_ap_done,
  output logic                    ap_start,
  output logic [XW-1:0]           crop_x0,
  output logic [YW-1:0]           crop_y0,
  output logic [XW-1:0]           cnt_col,
  output logic [YW-1:0]           cnt_row,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    err_timeout
);

  localparam logic [XW-1:0] MaxX    = XW'(IN_COLS - OUT_COLS);
  localparam logic [YW-1:0] MaxY    = YW'(IN_ROWS - OUT_ROWS);
  localparam logic [XW-1:0] ColLast = XW'(IN_COLS - 1);
  localparam logic [YW-1:0] RowLast = YW'(IN_ROWS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   crop_x0_q, crop_x0_d;
  logic [YW-1:0]   crop_y0_q, crop_y0_d;
  logic [XW-1:0]   cnt_col_q, cnt_col_d;
  logic [YW-1:0]   cnt_row_q, cnt_row_d;
  logic            done_seen_q, done_seen_d;
  logic            last_seen_q, last_seen_d;
  logic            frame_done_q, frame_done_d;
  logic            cfg_ready;
  logic            s_axis_tready;
  logic            beat;

`ifdef CROP_CTRL_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            err_timeout_q, err_timeout_d;
`endif

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_d       = state_q;
    crop_x0_d     = crop_x0_q;
    crop_y0_d     = crop_y0_q;
    cnt_col_d     = cnt_col_q;
    cnt_row_d     = cnt_row_q;
    done_seen_d   = done_seen_q;
    last_seen_d   = last_seen_q;
    frame_done_d  = 1'b0;
    cfg_ready     = 1'b0;
    s_axis_tready = 1'b0;
    ap_start      = 1'b0;
    beat          = 1'b0;
`ifdef CROP_CTRL_TIMEOUT_EN
    tmo_d         = tmo_q;
    err_timeout_d = err_timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        cfg_ready = cf_ap_ready;
        if (cfg_axis.cfg_valid && cf_ap_ready) begin
          crop_x0_d   = (cfg_axis.cfg_x0 > MaxX) ? MaxX : cfg_axis.cfg_x0;
          crop_y0_d   = (cfg_axis.cfg_y0 > MaxY) ? MaxY : cfg_axis.cfg_y0;
          cnt_col_d   = '0;
          cnt_row_d   = '0;
          done_seen_d = 1'b0;
          last_seen_d = 1'b0;
          state_d     = StStart;
        end
      end
      StStart: begin
        ap_start = 1'b1;
        state_d  = StRun;
      end
      StRun: begin
        s_axis_tready = cf_s_axis_tready;
        beat          = cfg_axis.s_axis_tvalid && cf_s_axis_tready;
        if (beat) begin
          if (cnt_col_q == ColLast) begin
            cnt_col_d = '0;
            if (cnt_row_q == RowLast) begin
              cnt_row_d   = '0;
              last_seen_d = 1'b1;
            end else begin
              cnt_row_d = cnt_row_q + 1'b1;
            end
          end else begin
            cnt_col_d = cnt_col_q + 1'b1;
          end
        end
        if (cf_ap_done) begin
          done_seen_d = 1'b1;
        end
        // Done and last beat may arrive in either order, including the same cycle
        if (last_seen_d && done_seen_d) begin
          frame_done_d = 1'b1;
          state_d      = StIdle;
        end else if (last_seen_d) begin
          state_d = StDrain;
`ifdef CROP_CTRL_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      StDrain: begin
        if (cf_ap_done || done_seen_q) begin
          done_seen_d  = 1'b1;
          frame_done_d = 1'b1;
          state_d      = StIdle;
        end
`ifdef CROP_CTRL_TIMEOUT_EN
        else if (tmo_q == TmoLast) begin
          // Give up on the filter; no frame_done for an abandoned frame
          err_timeout_d = 1'b1;
          state_d       = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= StIdle;
      crop_x0_q    <= '0;
      crop_y0_q    <= '0;
      cnt_col_q    <= '0;
      cnt_row_q    <= '0;
      done_seen_q  <= 1'b0;
      last_seen_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      crop_x0_q    <= crop_x0_d;
      crop_y0_q    <= crop_y0_d;
      cnt_col_q    <= cnt_col_d;
      cnt_row_q    <= cnt_row_d;
      done_seen_q  <= done_seen_d;
      last_seen_q  <= last_seen_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef CROP_CTRL_TIMEOUT_EN
  // DRAIN watchdog counter and sticky error flag
  always_ff @(posedge clk) begin
    if (srst) begin
      tmo_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      tmo_q         <= tmo_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign cfg_axis.cfg_ready     = cfg_ready;
  assign cfg_axis.s_axis_tready = s_axis_tready;
  assign crop_x0                = crop_x0_q;
  assign crop_y0                = crop_y0_q;
  assign cnt_col                = cnt_col_q;
  assign cnt_row                = cnt_row_q;
  assign busy                   = (state_q != StIdle);
  assign frame_done             = frame_done_q;

endmodule

// File: tb/tb_crop_frame_ctrl.sv
// Directed bench for crop_frame_ctrl: clamping, one-shot ap_start, raster counting under
// stalls, done-before/with/after the last beat, back-to-back frames, mid-frame reset and,
// when CROP_CTRL_TIMEOUT_EN is defined, the DRAIN watchdog.
module tb_crop_frame_ctrl;

  localparam int unsigned IN_ROWS  = 20;
  localparam int unsigned IN_COLS  = 20;
  localparam int unsigned OUT_ROWS = 10;
  localparam int unsigned OUT_COLS = 10;
  localparam int unsigned TMO      = 16;
  localparam int unsigned XW       = 5;
  localparam int unsigned YW       = 5;
  localparam int          NBEATS   = IN_ROWS * IN_COLS;

  logic          clk = 1'b0;
  logic          srst;
  logic          cf_s_axis_tready;
  logic          cf_ap_ready;
  logic          cf_ap_done;
  logic          ap_start;
  logic [XW-1:0] crop_x0;
  logic [YW-1:0] crop_y0;
  logic [XW-1:0] cnt_col;
  logic [YW-1:0] cnt_row;
  logic          busy;
  logic          frame_done;
  logic          err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crop_frame_ctrl_if #(.XW(XW), .YW(YW)) bus ();

  crop_frame_ctrl #(
    .IN_ROWS        (IN_ROWS),
    .IN_COLS        (IN_COLS),
    .OUT_ROWS       (OUT_ROWS),
    .OUT_COLS       (OUT_COLS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk              (clk),
    .srst             (srst),
    .cfg_axis         (bus),
    .cf_s_axis_tready (cf_s_axis_tready),
    .cf_ap_ready      (cf_ap_ready),
    .cf_ap_done       (cf_ap_done),
    .ap_start         (ap_start),
    .crop_x0          (crop_x0),
    .crop_y0          (crop_y0),
    .cnt_col          (cnt_col),
    .cnt_row          (cnt_row),
    .busy             (busy),
    .frame_done       (frame_done),
    .err_timeout      (err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called just after a negedge in IDLE; returns just after the negedge of the START cycle.
  task automatic start_frame(input int x, input int y, input int ex, input int ey);
    bus.cfg_valid     = 1'b1;
    bus.cfg_x0        = XW'(x);
    bus.cfg_y0        = YW'(y);
    bus.s_axis_tvalid = 1'b1;
    cf_s_axis_tready  = 1'b1;
    cf_ap_done        = 1'b0;
    #1;
    check("cfg_ready_idle", bus.cfg_ready, 1);
    check("ap_start_accept_cycle", ap_start, 0);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    #1;
    check("ap_start_pulse", ap_start, 1);
    check("start_tready", bus.s_axis_tready, 0);
    check("start_busy", busy, 1);
    check("start_cfg_ready", bus.cfg_ready, 0);
    check("start_frame_done", frame_done, 0);
    check("crop_x0", crop_x0, ex);
    check("crop_y0", crop_y0, ey);
  endtask

  // mode 0: tvalid/tready always 1; mode 1: tready toggles, tvalid random.
  // done_beat: beat index carrying cf_ap_done (0 = none). abort_beat: stop after that beat.
  // close 0: expect close right after last beat; 1: expect DRAIN then done; 2: return in DRAIN.
  task automatic run_frame(input int mode, input int done_beat, input int abort_beat,
                           input int close, input int ex, input int ey);
    int beats = 0;
    int cyc   = 0;
    int ecol  = 0;
    int erow  = 0;
    bit tog   = 1'b1;
    bit beat;
    while (beats < NBEATS && cyc < 4000) begin
      @(negedge clk);
      cf_s_axis_tready  = (mode == 0) ? 1'b1 : tog;
      tog               = ~tog;
      bus.s_axis_tvalid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      beat              = bus.s_axis_tvalid && cf_s_axis_tready;
      cf_ap_done        = beat && (beats + 1 == done_beat);
      #1;
      if (cyc == 0) check("ap_start_once", ap_start, 0);
      check("run_tready", bus.s_axis_tready, cf_s_axis_tready);
      if (beat) begin
        check("cnt_col", cnt_col, ecol);
        check("cnt_row", cnt_row, erow);
        if (ecol == IN_COLS - 1) begin
          ecol = 0;
          erow = (erow == IN_ROWS - 1) ? 0 : erow + 1;
        end else begin
          ecol++;
        end
        beats++;
      end
      cyc++;
      if (abort_beat != 0 && beats == abort_beat) break;
    end
    if (abort_beat != 0) return;
    check("beat_total", beats, NBEATS);
    @(negedge clk);
    bus.s_axis_tvalid = 1'b1;
    cf_s_axis_tready  = 1'b1;
    cf_ap_done        = 1'b0;
    #1;
    check("post_last_tready", bus.s_axis_tready, 0);
    check("post_last_col", cnt_col, 0);
    check("post_last_row", cnt_row, 0);
    if (close == 0) begin
      check("close_frame_done", frame_done, 1);
      check("close_busy", busy, 0);
      check("close_crop_x0", crop_x0, ex);
      check("close_crop_y0", crop_y0, ey);
    end else if (close == 1) begin
      check("drain_frame_done", frame_done, 0);
      check("drain_busy", busy, 1);
      repeat (19) begin
        @(negedge clk);
        #1;
        check("drain_tready", bus.s_axis_tready, 0);
        check("drain_busy", busy, 1);
        check("drain_no_done", frame_done, 0);
      end
      @(negedge clk);
      cf_ap_done = 1'b1;
      #1;
      check("drain_done_cycle_busy", busy, 1);
      @(negedge clk);
      cf_ap_done = 1'b0;
      #1;
      check("drain_frame_done", frame_done, 1);
      check("drain_close_busy", busy, 0);
      check("drain_crop_x0", crop_x0, ex);
      check("drain_crop_y0", crop_y0, ey);
    end
  endtask

  initial begin
    srst              = 1'b1;
    bus.cfg_valid     = 1'b0;
    bus.cfg_x0        = '0;
    bus.cfg_y0        = '0;
    bus.s_axis_tvalid = 1'b0;
    cf_s_axis_tready  = 1'b0;
    cf_ap_ready       = 1'b1;
    cf_ap_done        = 1'b0;
    repeat (2) @(negedge clk);
    srst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ap_start", ap_start, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err", err_timeout, 0);
    check("rst_crop_x0", crop_x0, 0);
    check("rst_crop_y0", crop_y0, 0);
    check("rst_cnt_col", cnt_col, 0);
    check("rst_cnt_row", cnt_row, 0);
    check("rst_tready", bus.s_axis_tready, 0);

    // Filter not ready: request must be held off
    cf_ap_ready   = 1'b0;
    bus.cfg_valid = 1'b1;
    #1;
    check("cfg_ready_blocked", bus.cfg_ready, 0);
    @(negedge clk);
    #1;
    check("no_accept_busy", busy, 0);
    cf_ap_ready   = 1'b1;
    bus.cfg_valid = 1'b0;

    // Full-rate frame, done arrives with the last beat
    start_frame(3, 4, 3, 4);
    run_frame(0, NBEATS, 0, 0, 3, 4);

    // Back-to-back accept in the frame_done cycle; stalled stream, early done
    start_frame(7, 1, 7, 1);
    run_frame(1, 150, 0, 0, 7, 1);

    // Clamp both axes; done withheld until 20 cycles into DRAIN
    start_frame(15, 19, 10, 10);
    run_frame(0, 0, 0, 1, 10, 10);

    // Exact upper limit unchanged; reset mid-frame at beat 137
    start_frame(10, 10, 10, 10);
    run_frame(0, 0, 137, 0, 10, 10);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    #1;
    check("srst_busy", busy, 0);
    check("srst_cnt_col", cnt_col, 0);
    check("srst_cnt_row", cnt_row, 0);
    check("srst_tready", bus.s_axis_tready, 0);
    check("srst_crop_x0", crop_x0, 0);

    // Fresh frame after reset; only y needs clamping
    start_frame(9, 12, 9, 10);
    run_frame(0, NBEATS, 0, 0, 9, 10);

`ifdef CROP_CTRL_TIMEOUT_EN
    // Filter never reports done: watchdog fires after TMO DRAIN cycles
    start_frame(0, 0, 0, 0);
    run_frame(0, 0, 0, 2, 0, 0);
    check("tmo_err_early", err_timeout, 0);
    repeat (TMO - 1) begin
      @(negedge clk);
      #1;
      check("tmo_err_pending", err_timeout, 0);
      check("tmo_busy", busy, 1);
    end
    @(negedge clk);
    #1;
    check("tmo_err_set", err_timeout, 1);
    check("tmo_idle", busy, 0);
    check("tmo_no_frame_done", frame_done, 0);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("tmo_err_sticky", err_timeout, 1);
      check("tmo_still_no_done", frame_done, 0);
    end
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    #1;
    check("tmo_err_cleared", err_timeout, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
